// File: rtl/cumsum_pkg.sv
// cumsum_pkg
//   Shared types and defaults for the cumulative-sum sequencing controller.
//   - cumsum_state_e : controller state encoding
//   - N_W_DEF        : default sample/count width
//   - DEB_CYCLES_DEF : default debounce length (10 ms at 50 MHz)
//   - deb_cnt_w()    : width of a counter that must reach DEB_CYCLES-1
package cumsum_pkg;

    localparam int N_W_DEF        = 8;
    localparam int DEB_CYCLES_DEF = 500000;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ARM        = 3'd1,
        ST_WAIT_KEY   = 3'd2,
        ST_ACCUM      = 3'd3,
        ST_RUN_REPORT = 3'd4,
        ST_REPORT     = 3'd5,
        ST_DONE       = 3'd6
    } cumsum_state_e;

    // The filter counter only has to count up to cycles-1.
    function automatic int deb_cnt_w(input int cycles);
        if (cycles < 2) begin
            return 1;
        end
        return $clog2(cycles);
    endfunction

endpackage

// File: rtl/cumsum_ctrl_key_debounce.sv
// key_debounce
//   Synchronizes an asynchronous level, filters it so that the output level
//   only follows after DEB_CYCLES consecutive samples that disagree with it,
//   and emits a one-cycle pulse when the filtered level falls.
//   Ports:
//     clk   in  system clock
//     srst  in  synchronous active-high reset (filter returns to RESET_LEVEL)
//     din   in  asynchronous input level
//     press out one-cycle pulse, coincident with the filtered level going low
module key_debounce
    import cumsum_pkg::*;
#(
    parameter int   DEB_CYCLES  = DEB_CYCLES_DEF,
    parameter logic RESET_LEVEL = 1'b1
) (
    input  logic clk,
    input  logic srst,
    input  logic din,
    output logic press
);

    localparam int SYNC_STAGES         = 2;
    localparam int CW                  = deb_cnt_w(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [CW-1:0]          cnt_reg;
    logic                   filt_reg;
    logic                   press_reg;
    logic                   synced;

    // Synchronizer chain: stage 0 samples the pin, each later stage the one before.
    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (srst) sync_reg[gi] <= RESET_LEVEL;
                    else      sync_reg[gi] <= din;
                end
            end else begin : g_next
                always_ff @(posedge clk) begin
                    if (srst) sync_reg[gi] <= RESET_LEVEL;
                    else      sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    assign synced = sync_reg[SYNC_STAGES-1];

    // Any sample agreeing with the filtered level restarts the run, so a
    // glitch shorter than DEB_CYCLES never reaches the output.
    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_reg   <= '0;
            filt_reg  <= RESET_LEVEL;
            press_reg <= 1'b0;
        end else begin
            press_reg <= 1'b0;
            if (synced == filt_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_MAX) begin
                cnt_reg   <= '0;
                filt_reg  <= synced;
                press_reg <= ~synced;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign press = press_reg;

endmodule

// File: rtl/cumsum_ctrl.sv
// cumsum_ctrl
//   Sequencing controller for the cumulative-sum calculator. Debounces the
//   data-entry key, latches the sample count on start, strobes the
//   accumulator and reports the result to the LCD driver over req/ack.
//   Optional build macro: CUMSUM_RUNNING_EN adds an intermediate LCD report
//   (lcd_final_o=0) after every non-final sample.
//   Ports:
//     clk_i, rst_i           clock, synchronous active-high reset
//     start_i                async run switch (rising edge starts, low aborts)
//     key_n_i                async data-entry key, active-low
//     n_i, data_i            sample count and sample value
//     acc_clr_o, acc_en_o    accumulator clear / accumulate strobes
//     sample_o, count_o      captured sample, samples accepted so far
//     lcd_req_o, lcd_final_o LCD request (held until lcd_ack_i) and report kind
//     lcd_ack_i              LCD driver accepted the request
//     busy_o, done_o         run in progress / final result reported
module cumsum_ctrl
    import cumsum_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int N_W        = N_W_DEF
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           start_i,
    input  logic           key_n_i,
    input  logic [N_W-1:0] n_i,
    input  logic [N_W-1:0] data_i,
    output logic           acc_clr_o,
    output logic           acc_en_o,
    output logic [N_W-1:0] sample_o,
    output logic [N_W-1:0] count_o,
    output logic           lcd_req_o,
    output logic           lcd_final_o,
    input  logic           lcd_ack_i,
    output logic           busy_o,
    output logic           done_o
);

    cumsum_state_e  state_reg, state_next;
    logic [N_W-1:0] n_q_reg;
    logic [N_W-1:0] count_reg;
    logic [N_W-1:0] sample_reg;
    logic [2:0]     start_sync_reg;
    logic           start_level;
    logic           start_rise;
    logic           key_press;
    logic [N_W-1:0] count_inc;

    key_debounce #(
        .DEB_CYCLES  (DEB_CYCLES),
        .RESET_LEVEL (1'b1)
    ) u_key_debounce (
        .clk   (clk_i),
        .srst  (rst_i),
        .din   (key_n_i),
        .press (key_press)
    );

    // Two synchronizer flops plus one history flop for edge detection.
    assign start_level = start_sync_reg[1];
    assign start_rise  = start_sync_reg[1] & ~start_sync_reg[2];
    assign count_inc   = count_reg + 1'b1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg      <= ST_IDLE;
            n_q_reg        <= '0;
            count_reg      <= '0;
            sample_reg     <= '0;
            start_sync_reg <= '0;
        end else begin
            state_reg      <= state_next;
            start_sync_reg <= {start_sync_reg[1:0], start_i};
            if (state_reg == ST_ARM) begin
                n_q_reg   <= n_i;
                count_reg <= '0;
            end
            if (state_reg == ST_ACCUM) begin
                count_reg <= count_inc;
            end
            if (state_reg == ST_WAIT_KEY && start_level && key_press) begin
                sample_reg <= data_i;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start_rise) state_next = ST_ARM;
            end
            ST_ARM: begin
                // n_q is being loaded on this same edge, so decide from n_i.
                if (n_i == '0) state_next = ST_REPORT;
                else           state_next = ST_WAIT_KEY;
            end
            ST_WAIT_KEY: begin
                if (!start_level)   state_next = ST_IDLE;
                else if (key_press) state_next = ST_ACCUM;
            end
            ST_ACCUM: begin
                if (count_inc == n_q_reg) state_next = ST_REPORT;
`ifdef CUMSUM_RUNNING_EN
                else                      state_next = ST_RUN_REPORT;
`else
                else                      state_next = ST_WAIT_KEY;
`endif
            end
`ifdef CUMSUM_RUNNING_EN
            ST_RUN_REPORT: begin
                if (!start_level)   state_next = ST_IDLE;
                else if (lcd_ack_i) state_next = ST_WAIT_KEY;
            end
`endif
            ST_REPORT: begin
                if (lcd_ack_i) state_next = ST_DONE;
            end
            ST_DONE: begin
                if (!start_level) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign acc_clr_o = (state_reg == ST_ARM);
    assign acc_en_o  = (state_reg == ST_ACCUM);
    assign sample_o  = sample_reg;
    assign count_o   = count_reg;
    assign busy_o    = (state_reg != ST_IDLE) && (state_reg != ST_DONE);
    assign done_o    = (state_reg == ST_DONE);
`ifdef CUMSUM_RUNNING_EN
    assign lcd_req_o   = (state_reg == ST_REPORT) || (state_reg == ST_RUN_REPORT);
    assign lcd_final_o = (state_reg == ST_REPORT);
`else
    assign lcd_req_o   = (state_reg == ST_REPORT);
    assign lcd_final_o = 1'b1;
`endif

endmodule

// File: tb/tb_cumsum_ctrl.sv
// tb_cumsum_ctrl
//   Directed bench for cumsum_ctrl with DEB_CYCLES=4. The stimulus pushes the
//   expected clear / accumulate / LCD-request events into a queue; an
//   independent monitor pops and compares whenever the DUT shows one.
module tb_cumsum_ctrl;

    localparam int N_W = 8;
    localparam int EV_CLR = 0;
    localparam int EV_ACC = 1;
    localparam int EV_REQ = 2;

    logic           clk = 1'b0;
    logic           rst_i = 1'b1;
    logic           start_i = 1'b0;
    logic           key_n_i = 1'b1;
    logic [N_W-1:0] n_i = '0;
    logic [N_W-1:0] data_i = '0;
    logic           lcd_ack_i = 1'b0;
    logic           acc_clr_o, acc_en_o, lcd_req_o, lcd_final_o, busy_o, done_o;
    logic [N_W-1:0] sample_o, count_o;

    typedef struct {
        int kind;
        int val;
        int cnt;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    logic req_prev = 1'b0;
    bit   cnt_pend = 1'b0;
    int   cnt_exp  = 0;

    cumsum_ctrl #(
        .DEB_CYCLES (4),
        .N_W        (N_W)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .key_n_i     (key_n_i),
        .n_i         (n_i),
        .data_i      (data_i),
        .acc_clr_o   (acc_clr_o),
        .acc_en_o    (acc_en_o),
        .sample_o    (sample_o),
        .count_o     (count_o),
        .lcd_req_o   (lcd_req_o),
        .lcd_final_o (lcd_final_o),
        .lcd_ack_i   (lcd_ack_i),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("ok   %s = %0d", name, act);
        end
    endtask

    task automatic push(input int kind, input int val, input int cnt);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        e.cnt  = cnt;
        exp_q.push_back(e);
    endtask

    task automatic take(input int kind, output ev_t e, output bit ok);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d, expected no event", kind);
            ok = 1'b0;
            e.kind = -1; e.val = 0; e.cnt = 0;
        end else begin
            e = exp_q.pop_front();
            check("event_kind", kind, e.kind);
            ok = (e.kind == kind);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Clean press: low long enough for sync + filter, then a released tail.
    task automatic press(input logic [N_W-1:0] val);
        data_i  = val;
        key_n_i = 1'b0;
        tick(6);
        key_n_i = 1'b1;
        tick(8);
    endtask

    task automatic wait_req_and_ack(input string name);
        int k = 0;
        while (lcd_req_o !== 1'b1 && k < 100) begin
            tick(1);
            k++;
        end
        if (lcd_req_o !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got lcd_req_o=%b, expected 1 within 100 cycles", name, lcd_req_o);
        end
        lcd_ack_i = 1'b1;
        tick(1);
        lcd_ack_i = 1'b0;
    endtask

    // Monitor: every DUT event must match the head of the expected queue.
    initial begin
        ev_t e;
        bit  ok;
        forever begin
            @(negedge clk);
            if (cnt_pend) begin
                check("count_after_acc", count_o, cnt_exp);
                cnt_pend = 1'b0;
            end
            if (rst_i !== 1'b1) begin
                if (acc_clr_o === 1'b1) begin
                    take(EV_CLR, e, ok);
                end
                if (acc_en_o === 1'b1) begin
                    take(EV_ACC, e, ok);
                    if (ok) begin
                        check("acc_sample", sample_o, e.val);
                        cnt_exp  = e.cnt;
                        cnt_pend = 1'b1;
                    end
                end
                if (lcd_req_o === 1'b1 && req_prev !== 1'b1) begin
                    take(EV_REQ, e, ok);
                    if (ok) begin
                        check("req_final", lcd_final_o, e.val);
                        check("req_count", count_o, e.cnt);
                    end
                end
            end
            req_prev = lcd_req_o;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end of test, expected finish before 1 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---------------- reset state ----------------
        tick(4);
        rst_i = 1'b0;
        tick(1);
        check("rst_acc_clr", acc_clr_o, 0);
        check("rst_acc_en",  acc_en_o,  0);
        check("rst_lcd_req", lcd_req_o, 0);
        check("rst_busy",    busy_o,    0);
        check("rst_done",    done_o,    0);
        check("rst_count",   count_o,   0);
        check("rst_sample",  sample_o,  0);

        // ---------------- N=3, samples 5,7,9 ----------------
        n_i = 8'd3;
        push(EV_CLR, 0, 0);
        start_i = 1'b1;
        tick(2);
        check("t1_clr_not_yet", acc_clr_o, 0);
        tick(1);
        check("t1_clr_at_arm", acc_clr_o, 1);
        tick(1);
        check("t1_busy", busy_o, 1);
        n_i = 8'd1;   // must not affect the running count
        push(EV_ACC, 5, 1);
        press(8'd5);
        push(EV_ACC, 7, 2);
        press(8'd7);
        push(EV_ACC, 9, 3);
        push(EV_REQ, 1, 3);
        press(8'd9);
        wait_req_and_ack("t1_req");
        check("t1_done", done_o, 1);
        check("t1_req_low", lcd_req_o, 0);
        check("t1_not_busy", busy_o, 0);
        start_i = 1'b0;
        tick(4);
        check("t1_done_cleared", done_o, 0);

        // ---------------- N=0 ----------------
        n_i = 8'd0;
        push(EV_CLR, 0, 0);
        push(EV_REQ, 1, 0);
        start_i = 1'b1;
        tick(3);
        wait_req_and_ack("t2_req");
        check("t2_done", done_o, 1);
        check("t2_count", count_o, 0);
        start_i = 1'b0;
        tick(4);

        // ---------------- bouncing key, N=1 ----------------
        n_i = 8'd1;
        push(EV_CLR, 0, 0);
        start_i = 1'b1;
        tick(4);
        data_i = 8'd33;
        for (int i = 0; i < 3; i++) begin
            key_n_i = 1'b0;
            tick(3);
            key_n_i = 1'b1;
            tick(3);
        end
        tick(6);
        check("t3_no_capture_count", count_o, 0);
        check("t3_still_busy", busy_o, 1);
        push(EV_ACC, 11, 1);
        push(EV_REQ, 1, 1);
        press(8'd11);
        wait_req_and_ack("t3_req");
        check("t3_done", done_o, 1);
        start_i = 1'b0;
        tick(4);

        // ---------------- abort after 1 of 4, then rerun N=2 ----------------
        n_i = 8'd4;
        push(EV_CLR, 0, 0);
        start_i = 1'b1;
        tick(4);
        push(EV_ACC, 3, 1);
        press(8'd3);
        start_i = 1'b0;
        tick(4);
        check("t4_abort_busy", busy_o, 0);
        check("t4_abort_done", done_o, 0);
        check("t4_abort_req",  lcd_req_o, 0);
        n_i = 8'd2;
        push(EV_CLR, 0, 0);
        start_i = 1'b1;
        tick(4);
        check("t4_rerun_count", count_o, 0);
        push(EV_ACC, 1, 1);
        press(8'd1);
        push(EV_ACC, 2, 2);
        push(EV_REQ, 1, 2);
        press(8'd2);
        wait_req_and_ack("t4_req");
        check("t4_done", done_o, 1);
        start_i = 1'b0;
        tick(4);

        // ---------------- reset while lcd_req_o=1 ----------------
        n_i = 8'd0;
        push(EV_CLR, 0, 0);
        push(EV_REQ, 1, 0);
        start_i = 1'b1;
        tick(6);
        check("t5_req_high", lcd_req_o, 1);
        rst_i   = 1'b1;
        start_i = 1'b0;
        tick(1);
        rst_i = 1'b0;
        check("t5_req",  lcd_req_o, 0);
        check("t5_busy", busy_o, 0);
        check("t5_done", done_o, 0);
        check("t5_clr",  acc_clr_o, 0);
        check("t5_en",   acc_en_o, 0);
        check("t5_count", count_o, 0);
        check("t5_sample", sample_o, 0);
        lcd_ack_i = 1'b1;
        tick(2);
        lcd_ack_i = 1'b0;
        tick(1);
        check("t5_ack_ignored_done", done_o, 0);
        check("t5_ack_ignored_busy", busy_o, 0);

`ifdef CUMSUM_RUNNING_EN
        // ---------------- running reports, N=2 ----------------
        n_i = 8'd2;
        push(EV_CLR, 0, 0);
        start_i = 1'b1;
        tick(4);
        push(EV_ACC, 4, 1);
        push(EV_REQ, 0, 1);
        press(8'd4);
        check("t6_run_req", lcd_req_o, 1);
        press(8'd6);   // discarded while the intermediate report is pending
        check("t6_discard_count", count_o, 1);
        lcd_ack_i = 1'b1;
        tick(1);
        lcd_ack_i = 1'b0;
        check("t6_back_to_wait", lcd_req_o, 0);
        push(EV_ACC, 8, 2);
        push(EV_REQ, 1, 2);
        press(8'd8);
        wait_req_and_ack("t6_req");
        check("t6_done", done_o, 1);
        start_i = 1'b0;
        tick(4);
`endif

        tick(5);
        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
